// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the sequential multiply/divide unit.
// The master offers requests and takes results; the slave is the unit.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_func;
  logic [WIDTH-1:0] req_rs;
  logic [WIDTH-1:0] req_rt;
  logic [3:0]       req_rd;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [3:0]       resp_rd;
  logic             resp_err;

  modport master (
    output req_valid,
    output req_func,
    output req_rs,
    output req_rt,
    output req_rd,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_rd,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_func,
    input  req_rs,
    input  req_rt,
    input  req_rd,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_rd,
    output resp_err
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential shift-add multiplier and restoring divider, one bit per cycle.
// Define MULDIV_DIV0_TRAP_EN to flag divide-by-zero via resp_err.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  output logic        busy,
  muldiv_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIXUP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       rd_q, rd_d;
  logic             dv_q, dv_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
`ifdef MULDIV_DIV0_TRAP_EN
  logic             err_q, err_d;
`endif

  logic             accept;
  logic             is_mul, is_div, is_rem;
  logic             uns, sa, sb, div0, last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] add, q_fix, r_fix;
  logic [WIDTH-1:0] div0_res;
  logic [WIDTH:0]   rem_sh, rem_sub;

  assign accept = bus.req_valid && bus.req_ready;
  assign is_mul = bus.req_func[3:1] == 3'b010;
  assign is_div = bus.req_func[3:1] == 3'b011;
  assign is_rem = bus.req_func[3:1] == 3'b100;
  assign uns    = bus.req_func[0];
  assign sa     = !uns && bus.req_rs[WIDTH-1];
  assign sb     = !uns && bus.req_rt[WIDTH-1];
  assign mag_a  = sa ? -bus.req_rs : bus.req_rs;
  assign mag_b  = sb ? -bus.req_rt : bus.req_rt;
  assign div0   = (is_div || is_rem)
               && (bus.req_rt == '0);
  assign last   = cnt_q == CW'(WIDTH - 1);

  assign add     = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh  = {acc_q, a_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign q_fix   = neg_q ? -a_q : a_q;
  assign r_fix   = rneg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV0_TRAP_EN
  assign div0_res = '0;
`else
  assign div0_res = is_div ? '1 : bus.req_rs;
`endif

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul)
            state_d = MUL;
          else if ((is_div || is_rem) && !div0)
            state_d = DIV;
          else
            state_d = DONE;
        end
      end
      MUL:     if (last) state_d = DONE;
      DIV:     if (last) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // FSM outputs and held response
  always_comb begin
    bus.req_ready  = (state_q == IDLE) && !flush;
    busy           = state_q != IDLE;
    bus.resp_valid = state_q == DONE;
    bus.resp_data  = res_q;
    bus.resp_rd    = rd_q;
`ifdef MULDIV_DIV0_TRAP_EN
    bus.resp_err   = err_q;
`else
    bus.resp_err   = 1'b0;
`endif
  end

  // Datapath: capture, iterate, sign fix-up
  always_comb begin
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    dv_d   = dv_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
`ifdef MULDIV_DIV0_TRAP_EN
    err_d  = err_q;
`endif
    unique case (1'b1)
      accept: begin
        cnt_d  = '0;
        rd_d   = bus.req_rd;
        dv_d   = is_div;
        acc_d  = '0;
        a_d    = is_mul ? bus.req_rs : mag_a;
        b_d    = is_mul ? bus.req_rt : mag_b;
        neg_d  = sa ^ sb;
        rneg_d = sa;
        res_d  = div0 ? div0_res : '0;
`ifdef MULDIV_DIV0_TRAP_EN
        err_d  = div0;
`endif
      end
      state_q == MUL: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        acc_d = add;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        if (last) res_d = add;
      end
      state_q == DIV: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (!rem_sub[WIDTH]) begin
          acc_d = rem_sub[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
      end
      state_q == FIXUP: begin
        res_d = dv_q ? q_fix : r_fix;
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rd_q   <= '0;
      dv_q   <= 1'b0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      err_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      dv_q   <= dv_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
`ifdef MULDIV_DIV0_TRAP_EN
      err_q  <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency,
// hold, flush and reset behaviour.
module tb_muldiv_seq;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  int   checks;
  int   failures;

`ifdef MULDIV_DIV0_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic issue(
    input logic [3:0]  f,
    input logic [31:0] rs,
    input logic [31:0] rt,
    input logic [3:0]  rd
  );
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_func  = f;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
    bus.req_rd    = rd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 200);
  endtask

  task automatic run_op(
    input string       tag,
    input logic [3:0]  f,
    input logic [31:0] rs,
    input logic [31:0] rt,
    input logic [3:0]  rd,
    input int          exp_lat,
    input logic [31:0] exp_d,
    input logic        exp_e
  );
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    issue(f, rs, rt, rd);
    wait_resp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, bus.resp_data, exp_d);
    chk({tag, "_rd"}, 32'(bus.resp_rd), 32'(rd));
    chk({tag, "_err"}, 32'(bus.resp_err),
        32'(exp_e));
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_func   = 4'h0;
    bus.req_rs     = '0;
    bus.req_rt     = '0;
    bus.req_rd     = 4'h0;
    bus.resp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_data", bus.resp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 32'(bus.req_ready), 32'd1);

    run_op("mul_s", 4'h4, 32'd7, 32'hFFFF_FFFD,
           4'h3, 33, 32'hFFFF_FFEB, 1'b0);
    run_op("mul_u", 4'h5, 32'h0001_0000,
           32'h0001_0001, 4'h5, 33,
           32'h0001_0000, 1'b0);
    run_op("div_s", 4'h6, 32'hFFFF_FFF9, 32'd2,
           4'h1, 34, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_s", 4'h8, 32'hFFFF_FFF9, 32'd2,
           4'h2, 34, 32'hFFFF_FFFF, 1'b0);
    run_op("divu", 4'h7, 32'hFFFF_FFFF, 32'h10,
           4'h4, 34, 32'h0FFF_FFFF, 1'b0);
    run_op("remu", 4'h9, 32'hFFFF_FFFF, 32'h10,
           4'h6, 34, 32'h0000_000F, 1'b0);
    run_op("div_ovf", 4'h6, 32'h8000_0000,
           32'hFFFF_FFFF, 4'h7, 34,
           32'h8000_0000, 1'b0);
    run_op("rem_ovf", 4'h8, 32'h8000_0000,
           32'hFFFF_FFFF, 4'h8, 34, 32'd0, 1'b0);
    run_op("div_neg", 4'h6, 32'd7, 32'hFFFF_FFFE,
           4'hA, 34, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_neg", 4'h8, 32'd7, 32'hFFFF_FFFE,
           4'hB, 34, 32'd1, 1'b0);
    run_op("div0", 4'h6, 32'd5, 32'd0, 4'hD, 1,
           TRAP ? 32'd0 : 32'hFFFF_FFFF, TRAP);
    run_op("rem0", 4'h8, 32'd5, 32'd0, 4'hE, 1,
           TRAP ? 32'd0 : 32'd5, TRAP);
    run_op("bad_f0", 4'h0, 32'd9, 32'd3, 4'h1, 1,
           32'd0, 1'b0);
    run_op("bad_ff", 4'hF, 32'd9, 32'd3, 4'h2, 1,
           32'd0, 1'b0);

    issue(4'h7, 32'd100, 32'd7, 4'h9);
    wait_resp(lat);
    chk("hold_lat", 32'(lat), 32'd34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_data", bus.resp_data, 32'd14);
      chk("hold_rd", 32'(bus.resp_rd), 32'd9);
      chk("hold_rdy", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("hold_rel_v", 32'(bus.resp_valid), 32'd0);
    chk("hold_rel_b", 32'(busy), 32'd0);
    chk("hold_rel_r", 32'(bus.req_ready), 32'd1);

    issue(4'h4, 32'd3, 32'd5, 4'h6);
    repeat (10) @(negedge clk);
    chk("fl_busy0", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_rdy", 32'(bus.req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    chk("fl_noresp", 32'(seen), 32'd0);

    issue(4'h6, 32'd1000, 32'd3, 4'hC);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mr_valid", 32'(bus.resp_valid), 32'd0);
    chk("mr_data", bus.resp_data, 32'd0);
    chk("mr_rd", 32'(bus.resp_rd), 32'd0);
    chk("mr_err", 32'(bus.resp_err), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mr_rdy", 32'(bus.req_ready), 32'd1);
    chk("mr_busy2", 32'(busy), 32'd0);

    run_op("post_rst", 4'h5, 32'd6, 32'd7,
           4'h3, 33, 32'd42, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
